// File: rtl/axi_rd_arbiter_2to1.sv
// Two-requester AXI4 read-channel arbiter: round-robin AR grant into a one-entry output
// register, source tag in the ID MSB, R beats routed back by that tag, per-requester burst limit.
module axi_rd_arbiter_2to1 #(
  parameter int unsigned AXI_ID_WIDTH    = 8,
  parameter int unsigned AXI_ADDR_WIDTH  = 40,
  parameter int unsigned AXI_DATA_WIDTH  = 128,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  // requester 0
  input  logic                      s0_ar_valid,
  output logic                      s0_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_ar_addr,
  input  logic [AXI_ID_WIDTH-2:0]   s0_ar_id,
  input  logic [7:0]                s0_ar_len,
  input  logic [2:0]                s0_ar_size,
  input  logic [1:0]                s0_ar_burst,
  output logic                      s0_r_valid,
  input  logic                      s0_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] s0_r_data,
  output logic [AXI_ID_WIDTH-2:0]   s0_r_id,
  output logic [1:0]                s0_r_resp,
  output logic                      s0_r_last,
  // requester 1
  input  logic                      s1_ar_valid,
  output logic                      s1_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_ar_addr,
  input  logic [AXI_ID_WIDTH-2:0]   s1_ar_id,
  input  logic [7:0]                s1_ar_len,
  input  logic [2:0]                s1_ar_size,
  input  logic [1:0]                s1_ar_burst,
  output logic                      s1_r_valid,
  input  logic                      s1_r_ready,
  output logic [AXI_DATA_WIDTH-1:0] s1_r_data,
  output logic [AXI_ID_WIDTH-2:0]   s1_r_id,
  output logic [1:0]                s1_r_resp,
  output logic                      s1_r_last,
  // memory side
  output logic                      m_ar_valid,
  input  logic                      m_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] m_ar_addr,
  output logic [AXI_ID_WIDTH-1:0]   m_ar_id,
  output logic [7:0]                m_ar_len,
  output logic [2:0]                m_ar_size,
  output logic [1:0]                m_ar_burst,
  input  logic                      m_r_valid,
  output logic                      m_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] m_r_data,
  input  logic [AXI_ID_WIDTH-1:0]   m_r_id,
  input  logic [1:0]                m_r_resp,
  input  logic                      m_r_last,
  // status
  output logic [3:0]                outstanding0,
  output logic [3:0]                outstanding1,
  output logic                      err_unexpected_r
);

  localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

  logic                      ar_valid_q, ar_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q;
  logic [7:0]                ar_len_q;
  logic [2:0]                ar_size_q;
  logic [1:0]                ar_burst_q;
  logic                      rr_q, rr_d;  // 0: s0 preferred on contention
  logic [3:0]                out0_q, out0_d, out1_q, out1_d;
  logic                      err_q, err_d;

  logic slot_free, elig0, elig1, grant0, grant1;
  logic r_sel, r_last_hs, dec0, dec1;

  function automatic logic [3:0] cnt_next(logic [3:0] cnt, logic inc, logic dec);
    logic [3:0] res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + 4'd1;
    end else if (dec && !inc && cnt != 4'd0) begin
      res = cnt - 4'd1;
    end
    return res;
  endfunction

  always_comb begin
    slot_free = !ar_valid_q || m_ar_ready;
    elig0     = s0_ar_valid && (out0_q < MaxOut);
    elig1     = s1_ar_valid && (out1_q < MaxOut);
    grant0    = !reset && slot_free && elig0 && (!elig1 || !rr_q);
    grant1    = !reset && slot_free && elig1 && (!elig0 || rr_q);

    r_sel     = m_r_id[AXI_ID_WIDTH-1];
    r_last_hs = m_r_valid && m_r_ready && m_r_last;
    dec0      = r_last_hs && !r_sel;
    dec1      = r_last_hs && r_sel;

    ar_valid_d = ar_valid_q;
    if (grant0 || grant1) begin
      ar_valid_d = 1'b1;
    end else if (m_ar_ready) begin
      ar_valid_d = 1'b0;
    end

    rr_d = rr_q;
    if (grant0) rr_d = 1'b1;
    if (grant1) rr_d = 1'b0;

    out0_d = cnt_next(out0_q, grant0, dec0);
    out1_d = cnt_next(out1_q, grant1, dec1);
    // Beat with no matching burst is still delivered; only flagged.
    err_d  = err_q || (dec0 && out0_q == 4'd0) || (dec1 && out1_q == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      rr_q       <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ar_valid_q <= ar_valid_d;
      rr_q       <= rr_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      err_q      <= err_d;
      if (grant0 || grant1) begin
        ar_addr_q  <= grant1 ? s1_ar_addr : s0_ar_addr;
        ar_id_q    <= grant1 ? {1'b1, s1_ar_id} : {1'b0, s0_ar_id};
        ar_len_q   <= grant1 ? s1_ar_len : s0_ar_len;
        ar_size_q  <= grant1 ? s1_ar_size : s0_ar_size;
        ar_burst_q <= grant1 ? s1_ar_burst : s0_ar_burst;
      end
    end
  end

  assign s0_ar_ready = grant0;
  assign s1_ar_ready = grant1;

  assign m_ar_valid = ar_valid_q;
  assign m_ar_addr  = ar_addr_q;
  assign m_ar_id    = ar_id_q;
  assign m_ar_len   = ar_len_q;
  assign m_ar_size  = ar_size_q;
  assign m_ar_burst = ar_burst_q;

  assign s0_r_valid = m_r_valid && !r_sel;
  assign s1_r_valid = m_r_valid && r_sel;
  assign m_r_ready  = r_sel ? s1_r_ready : s0_r_ready;
  assign s0_r_data  = m_r_data;
  assign s1_r_data  = m_r_data;
  assign s0_r_id    = m_r_id[AXI_ID_WIDTH-2:0];
  assign s1_r_id    = m_r_id[AXI_ID_WIDTH-2:0];
  assign s0_r_resp  = m_r_resp;
  assign s1_r_resp  = m_r_resp;
  assign s0_r_last  = m_r_last;
  assign s1_r_last  = m_r_last;

  assign outstanding0     = out0_q;
  assign outstanding1     = out1_q;
  assign err_unexpected_r = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Bench for axi_rd_arbiter_2to1: directed scenarios plus a randomized run against a
// transaction-level model of grants, burst counts and the error flag.
module tb_axi_rd_arbiter_2to1;

  localparam int MaxOut = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
  logic [39:0]  s0_ar_addr, s1_ar_addr, m_ar_addr;
  logic [6:0]   s0_ar_id, s1_ar_id, s0_r_id, s1_r_id;
  logic [7:0]   s0_ar_len, s1_ar_len, m_ar_len;
  logic [2:0]   s0_ar_size, s1_ar_size, m_ar_size;
  logic [1:0]   s0_ar_burst, s1_ar_burst, m_ar_burst;
  logic         s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready;
  logic [127:0] s0_r_data, s1_r_data, m_r_data;
  logic [1:0]   s0_r_resp, s1_r_resp, m_r_resp;
  logic         s0_r_last, s1_r_last, m_r_last;
  logic         m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [7:0]   m_ar_id, m_r_id;
  logic [3:0]   outstanding0, outstanding1;
  logic         err_unexpected_r;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          exp_out[2];
  int          exp_pref;  // requester that wins when both are eligible
  bit          exp_mvalid;
  bit          exp_err;
  logic [7:0]  exp_mid;
  logic [39:0] exp_maddr;
  logic [7:0]  exp_mlen;

  axi_rd_arbiter_2to1 dut (
    .clk(clk), .reset(reset),
    .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr),
    .s0_ar_id(s0_ar_id), .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size),
    .s0_ar_burst(s0_ar_burst), .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
    .s0_r_data(s0_r_data), .s0_r_id(s0_r_id), .s0_r_resp(s0_r_resp), .s0_r_last(s0_r_last),
    .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr),
    .s1_ar_id(s1_ar_id), .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size),
    .s1_ar_burst(s1_ar_burst), .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
    .s1_r_data(s1_r_data), .s1_r_id(s1_r_id), .s1_r_resp(s1_r_resp), .s1_r_last(s1_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_id(m_ar_id), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .outstanding0(outstanding0), .outstanding1(outstanding1),
    .err_unexpected_r(err_unexpected_r)
  );

  always #5 clk = ~clk;

  // Which requester the arbiter should accept this cycle, -1 for none.
  function automatic int predict_grant();
    bit free, e0, e1;
    if (reset) return -1;
    free = !exp_mvalid || m_ar_ready;
    e0   = s0_ar_valid && exp_out[0] < MaxOut;
    e1   = s1_ar_valid && exp_out[1] < MaxOut;
    if (!free || (!e0 && !e1)) return -1;
    if (e0 && e1) return exp_pref;
    return e0 ? 0 : 1;
  endfunction

  // Advance the model by the current cycle's transactions, then cross the clock edge.
  task automatic tick();
    int g, rn;
    bit rhs, inc, dec;
    g   = predict_grant();
    rn  = int'(m_r_id[7]);
    rhs = m_r_valid && m_r_last && (rn == 1 ? s1_r_ready : s0_r_ready);
    if (reset) begin
      exp_out[0] = 0;
      exp_out[1] = 0;
      exp_pref   = 0;
      exp_mvalid = 0;
      exp_err    = 0;
    end else begin
      if (rhs && exp_out[rn] == 0) exp_err = 1;
      if (g >= 0) begin
        exp_mvalid = 1;
        exp_mid    = (g == 1) ? {1'b1, s1_ar_id} : {1'b0, s0_ar_id};
        exp_maddr  = (g == 1) ? s1_ar_addr : s0_ar_addr;
        exp_mlen   = (g == 1) ? s1_ar_len : s0_ar_len;
        exp_pref   = 1 - g;
      end else if (m_ar_ready) begin
        exp_mvalid = 0;
      end
      for (int n = 0; n < 2; n++) begin
        inc = (g == n);
        dec = rhs && (rn == n);
        if (inc && !dec) exp_out[n] = exp_out[n] + 1;
        else if (dec && !inc && exp_out[n] > 0) exp_out[n] = exp_out[n] - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_ar_valid = 0; s0_ar_addr = '0; s0_ar_id = '0; s0_ar_len = '0;
    s0_ar_size  = 3'd4; s0_ar_burst = 2'd1;
    s1_ar_valid = 0; s1_ar_addr = '0; s1_ar_id = '0; s1_ar_len = '0;
    s1_ar_size  = 3'd4; s1_ar_burst = 2'd1;
    s0_r_ready = 1; s1_r_ready = 1;
    m_ar_ready = 1; m_r_valid = 0; m_r_data = '0; m_r_id = '0; m_r_resp = '0; m_r_last = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    s0_ar_valid = 1;
    s1_ar_valid = 1;
    tick();
    tick();
    #4;
    total++;
    if (m_ar_valid !== 1'b0) begin
      bad++; $display("FAIL reset_m_ar_valid got=%b want=0", m_ar_valid);
    end
    total++;
    if ({s0_ar_ready, s1_ar_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ar_ready got=%b%b want=00", s0_ar_ready, s1_ar_ready);
    end
    total++;
    if ({outstanding0, outstanding1, err_unexpected_r} !== 9'd0) begin
      bad++; $display("FAIL reset_status got=%0d/%0d/%b want=0/0/0",
                      outstanding0, outstanding1, err_unexpected_r);
    end
    idle_inputs();
    tick();
    reset = 0;
  endtask

  task automatic test_single();
    logic [127:0] d;
    do_reset();
    s0_ar_valid = 1; s0_ar_addr = 40'h001c000000; s0_ar_id = 7'h05; s0_ar_len = 8'd3;
    #4;
    total++;
    if (s0_ar_ready !== 1'b1 || s1_ar_ready !== 1'b0 || m_ar_valid !== 1'b0) begin
      bad++; $display("FAIL single_grant got=%b%b%b want=100", s0_ar_ready, s1_ar_ready,
                      m_ar_valid);
    end
    tick();
    s0_ar_valid = 0;
    #4;
    total++;
    if (m_ar_valid !== 1'b1 || m_ar_id !== 8'h05 || m_ar_addr !== 40'h001c000000 ||
        m_ar_len !== 8'd3) begin
      bad++; $display("FAIL single_load got=%b id=%h addr=%h len=%0d want=1 05 1c000000 3",
                      m_ar_valid, m_ar_id, m_ar_addr, m_ar_len);
    end
    total++;
    if (outstanding0 !== 4'd1) begin
      bad++; $display("FAIL single_out_inc got=%0d want=1", outstanding0);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_r_valid = 1; m_r_id = 8'h05; m_r_last = (b == 3); m_r_data = d; m_r_resp = 2'(b);
      #4;
      total++;
      if (s0_r_valid !== 1'b1 || s1_r_valid !== 1'b0 || s0_r_data !== d || s0_r_id !== 7'h05 ||
          s0_r_last !== (b == 3) || s0_r_resp !== 2'(b) || outstanding0 !== 4'd1) begin
        bad++; $display("FAIL single_beat%0d got v=%b%b id=%h last=%b out=%0d want v=10 id=05",
                        b, s0_r_valid, s1_r_valid, s0_r_id, s0_r_last, outstanding0);
      end
      tick();
    end
    m_r_valid = 0; m_r_last = 0;
    #4;
    total++;
    if (outstanding0 !== 4'd0 || err_unexpected_r !== 1'b0) begin
      bad++; $display("FAIL single_out_dec got=%0d err=%b want=0 0", outstanding0,
                      err_unexpected_r);
    end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    s0_ar_valid = 1; s1_ar_valid = 1;
    for (int i = 0; i < 6; i++) begin
      s0_ar_addr = 40'($urandom()); s1_ar_addr = 40'($urandom());
      s0_ar_id = 7'($urandom()); s1_ar_id = 7'($urandom());
      #4;
      total++;
      if (s0_ar_ready !== (i % 2 == 0) || s1_ar_ready !== (i % 2 == 1)) begin
        bad++; $display("FAIL contention_grant%0d got=%b%b want s0=%0d", i, s0_ar_ready,
                        s1_ar_ready, i % 2 == 0);
      end
      tick();
      total++;
      if (m_ar_valid !== 1'b1 || m_ar_id[7] !== 1'(i % 2) || m_ar_id !== exp_mid) begin
        bad++; $display("FAIL contention_id%0d got=%h want=%h", i, m_ar_id, exp_mid);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [39:0] a0;
    do_reset();
    m_ar_ready = 0;
    a0 = 40'h12_3456_7890;
    s0_ar_valid = 1; s0_ar_addr = a0; s0_ar_id = 7'h11;
    #4;
    tick();
    s1_ar_valid = 1; s1_ar_addr = 40'h00_aaaa_0000; s1_ar_id = 7'h22;
    for (int i = 0; i < 5; i++) begin
      s0_ar_addr = 40'($urandom());
      #4;
      total++;
      if (s0_ar_ready !== 1'b0 || s1_ar_ready !== 1'b0 || m_ar_valid !== 1'b1 ||
          m_ar_addr !== a0 || m_ar_id !== 8'h11) begin
        bad++; $display("FAIL backpressure_hold%0d got rdy=%b%b v=%b addr=%h id=%h", i,
                        s0_ar_ready, s1_ar_ready, m_ar_valid, m_ar_addr, m_ar_id);
      end
      tick();
    end
    m_ar_ready = 1;
    #4;
    total++;
    if (s1_ar_ready !== 1'b1 || s0_ar_ready !== 1'b0) begin
      bad++; $display("FAIL backpressure_regrant got=%b%b want=01", s0_ar_ready, s1_ar_ready);
    end
    tick();
    total++;
    if (m_ar_valid !== 1'b1 || m_ar_id !== 8'ha2 || m_ar_addr !== 40'h00_aaaa_0000) begin
      bad++; $display("FAIL backpressure_next got v=%b id=%h addr=%h want=1 a2 00aaaa0000",
                      m_ar_valid, m_ar_id, m_ar_addr);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_limit();
    do_reset();
    s1_ar_valid = 1;
    for (int i = 0; i < MaxOut; i++) begin
      s1_ar_id = 7'(i);
      #4;
      total++;
      if (s1_ar_ready !== 1'b1) begin
        bad++; $display("FAIL limit_grant%0d got=%b want=1", i, s1_ar_ready);
      end
      tick();
    end
    s0_ar_valid = 1;
    #4;
    total++;
    if (s1_ar_ready !== 1'b0 || s0_ar_ready !== 1'b1 || outstanding1 !== 4'(MaxOut)) begin
      bad++; $display("FAIL limit_block got=%b%b out1=%0d want=10 4", s0_ar_ready,
                      s1_ar_ready, outstanding1);
    end
    tick();
    s0_ar_valid = 0;
    m_r_valid = 1; m_r_id = 8'h80; m_r_last = 1;
    #4;
    total++;
    if (s1_ar_ready !== 1'b0 || s1_r_valid !== 1'b1) begin
      bad++; $display("FAIL limit_same_cycle got rdy=%b rv=%b want=0 1", s1_ar_ready,
                      s1_r_valid);
    end
    tick();
    m_r_valid = 0; m_r_last = 0;
    #4;
    total++;
    if (s1_ar_ready !== 1'b1 || outstanding1 !== 4'(MaxOut - 1)) begin
      bad++; $display("FAIL limit_reenable got rdy=%b out1=%0d want=1 3", s1_ar_ready,
                      outstanding1);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    s1_ar_valid = 1; s1_ar_id = 7'h03;
    #4;
    tick();
    m_r_valid = 1; m_r_id = 8'h83; m_r_last = 1; s0_r_ready = 0; s1_r_ready = 1;
    #4;
    total++;
    if (s1_r_valid !== 1'b1 || s0_r_valid !== 1'b0 || s1_r_id !== 7'h03 ||
        m_r_ready !== 1'b1 || s1_ar_ready !== 1'b1) begin
      bad++; $display("FAIL simul_route got v=%b%b id=%h mrdy=%b arrdy=%b want 01 03 1 1",
                      s0_r_valid, s1_r_valid, s1_r_id, m_r_ready, s1_ar_ready);
    end
    tick();
    s1_ar_valid = 0;
    s0_r_ready = 1; s1_r_ready = 0;
    #4;
    total++;
    if (outstanding1 !== 4'd1 || err_unexpected_r !== 1'b0) begin
      bad++; $display("FAIL simul_count got=%0d err=%b want=1 0", outstanding1,
                      err_unexpected_r);
    end
    total++;
    if (m_r_ready !== 1'b0) begin
      bad++; $display("FAIL simul_ready_sel got=%b want=0", m_r_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_error_reset();
    do_reset();
    m_r_valid = 1; m_r_id = 8'h00; m_r_last = 1; s0_r_ready = 1;
    #4;
    total++;
    if (s0_r_valid !== 1'b1 || err_unexpected_r !== 1'b0) begin
      bad++; $display("FAIL err_deliver got v=%b err=%b want=1 0", s0_r_valid,
                      err_unexpected_r);
    end
    tick();
    m_r_valid = 0; m_r_last = 0;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++;
      if (err_unexpected_r !== 1'b1 || outstanding0 !== 4'd0) begin
        bad++; $display("FAIL err_sticky%0d got err=%b out0=%0d want=1 0", i,
                        err_unexpected_r, outstanding0);
      end
      tick();
    end
    m_ar_ready = 0; s0_ar_valid = 1; s0_ar_addr = 40'h55;
    #4;
    tick();
    reset = 1;
    #4;
    tick();
    #4;
    total++;
    if (m_ar_valid !== 1'b0 || err_unexpected_r !== 1'b0 || s0_ar_ready !== 1'b0) begin
      bad++; $display("FAIL err_reset got v=%b err=%b rdy=%b want=0 0 0", m_ar_valid,
                      err_unexpected_r, s0_ar_ready);
    end
    tick();
    reset = 0; m_ar_ready = 1; s1_ar_valid = 1;
    #4;
    total++;
    if (s0_ar_ready !== 1'b1 || s1_ar_ready !== 1'b0) begin
      bad++; $display("FAIL err_rr_restart got=%b%b want=10", s0_ar_ready, s1_ar_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int g, n;
    bit sel;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      s0_ar_valid = ($urandom_range(0, 3) != 0);
      s1_ar_valid = ($urandom_range(0, 3) != 0);
      s0_ar_addr = 40'({$urandom(), $urandom()}); s1_ar_addr = 40'({$urandom(), $urandom()});
      s0_ar_id = 7'($urandom()); s1_ar_id = 7'($urandom());
      s0_ar_len = 8'($urandom()); s1_ar_len = 8'($urandom());
      m_ar_ready = ($urandom_range(0, 3) != 0);
      s0_r_ready = ($urandom_range(0, 3) != 0);
      s1_r_ready = ($urandom_range(0, 3) != 0);
      n = int'($urandom_range(0, 1));
      m_r_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      m_r_resp = 2'($urandom());
      m_r_id = {1'(n), 7'($urandom())};
      m_r_last = ($urandom_range(0, 2) == 0);
      m_r_valid = (exp_out[n] > 0) && ($urandom_range(0, 1) == 1);
      #4;
      g = predict_grant();
      sel = m_r_id[7];
      total++;
      if (s0_ar_ready !== (g == 0) || s1_ar_ready !== (g == 1)) begin
        bad++; $display("FAIL rand_grant c=%0d got=%b%b want g=%0d", c, s0_ar_ready,
                        s1_ar_ready, g);
      end
      total++;
      if (m_ar_valid !== exp_mvalid ||
          (exp_mvalid && (m_ar_id !== exp_mid || m_ar_addr !== exp_maddr ||
                          m_ar_len !== exp_mlen))) begin
        bad++; $display("FAIL rand_ar c=%0d got v=%b id=%h addr=%h want v=%b id=%h addr=%h", c,
                        m_ar_valid, m_ar_id, m_ar_addr, exp_mvalid, exp_mid, exp_maddr);
      end
      total++;
      if (outstanding0 !== 4'(exp_out[0]) || outstanding1 !== 4'(exp_out[1]) ||
          err_unexpected_r !== exp_err) begin
        bad++; $display("FAIL rand_status c=%0d got=%0d/%0d/%b want=%0d/%0d/%b", c,
                        outstanding0, outstanding1, err_unexpected_r, exp_out[0], exp_out[1],
                        exp_err);
      end
      total++;
      if (s0_r_valid !== (m_r_valid && !sel) || s1_r_valid !== (m_r_valid && sel) ||
          m_r_ready !== (sel ? s1_r_ready : s0_r_ready) ||
          (sel ? s1_r_data : s0_r_data) !== m_r_data ||
          (sel ? s1_r_id : s0_r_id) !== m_r_id[6:0] ||
          (sel ? s1_r_last : s0_r_last) !== m_r_last) begin
        bad++; $display("FAIL rand_route c=%0d got v=%b%b mrdy=%b for id=%h", c, s0_r_valid,
                        s1_r_valid, m_r_ready, m_r_id);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    exp_out[0] = 0; exp_out[1] = 0; exp_pref = 0; exp_mvalid = 0; exp_err = 0;
    exp_mid = '0; exp_maddr = '0; exp_mlen = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_limit();
    test_simultaneous();
    test_error_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
